// File: rtl/beeb_fast_ram_loader.sv
// -----------------------------------------------------------------------------
// beeb_fast_ram_loader
//
// Fast-memory stage that sits directly below the accelerator core. It holds
// 64 KB of dual-port synchronous RAM and, after every reset, copies a ROM image
// out of SPI flash (READ 0x03) into that RAM. load_done keeps the core in reset
// until the copy has finished.
//
// Ports
//   cpu_clk         in   1   sole clock
//   reset           in   1   asynchronous, active-high reset
//   ram_cpu_A       in   16  CPU port address
//   ram_cpu_we      in   1   CPU port write enable (ignored until load_done)
//   ram_cpu_D_wr    in   8   CPU port write data
//   ram_cpu_D_rd    out  8   CPU port read data, 1-cycle latency, read-first
//   ram_scrub_A     in   16  scrub port address
//   ram_scrub_D_rd  out  8   scrub port read data, 1-cycle latency, read-first
//   spi_cs_n        out  1   flash chip select, active low
//   spi_sck         out  1   flash clock, SPI mode 0
//   spi_mosi        out  1   flash data out, MSB first
//   spi_miso        in   1   flash data in
//   load_done       out  1   image loaded; CPU may run
//
// Port timing: there is no valid/ready handshake. Both RAM ports accept an
// address every cycle; the address present at edge N is read at edge N and
// its data is valid after that edge. A write and a read on the same edge
// return the byte stored before the write.
// -----------------------------------------------------------------------------
module beeb_fast_ram_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [15:0] LOAD_START = 16'h8000,
    parameter logic [16:0] LOAD_LEN   = 17'h04000,
    parameter int          SPI_DIV    = 2
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] ram_cpu_A,
    input  logic        ram_cpu_we,
    input  logic [7:0]  ram_cpu_D_wr,
    output logic [7:0]  ram_cpu_D_rd,
    input  logic [15:0] ram_scrub_A,
    output logic [7:0]  ram_scrub_D_rd,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        load_done
);

    // One bit lasts 2*SPI_DIV cycles; ph counts the cycles within a bit.
    localparam int PH_MAX = 2 * SPI_DIV - 1;
    localparam int PH_W   = $clog2(2 * SPI_DIV + 1);

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            cs_n_q, cs_n_d;
    logic            done_q, done_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [4:0]      bit_q, bit_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [6:0]      shift_q, shift_d;
    logic [16:0]     idx_q, idx_d;

    logic            bit_end;
    logic            ld_we;
    logic [15:0]     ld_addr;
    logic [7:0]      ld_data;

    // -------------------------------------------------------------------------
    // Loader FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CMD;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            ph_q    <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Loader FSM: next state and loader write strobe
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        done_d  = done_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        ld_we   = 1'b0;
        ld_addr = LOAD_START + idx_q[15:0];
        // The 8th bit is taken straight from miso so the byte lands on the
        // same edge that samples it.
        ld_data = {shift_q, spi_miso};
        bit_end = (ph_q == PH_W'(PH_MAX));

        case (state_q)
            ST_CMD: begin
                if (cs_n_q) begin
                    // First cycle after reset: either skip straight to DONE
                    // or select the flash and start the command.
                    if (LOAD_LEN == 17'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cs_n_d = 1'b0;
                        ph_d   = '0;
                        bit_d  = '0;
                        cmd_d  = {8'h03, FLASH_BASE};
                    end
                end else if (bit_end) begin
                    ph_d  = '0;
                    cmd_d = {cmd_q[30:0], 1'b0};
                    if (bit_q == 5'd31) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                        idx_d   = '0;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    ph_d    = '0;
                    shift_d = {shift_q[5:0], spi_miso};
                    if (bit_q == 5'd7) begin
                        ld_we = 1'b1;
                        bit_d = '0;
                        idx_d = idx_q + 17'd1;
                        if (idx_q == LOAD_LEN - 17'd1) begin
                            state_d = ST_DONE;
                            cs_n_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            ST_DONE: begin
                // Terminal until the next reset.
            end

            default: begin
                state_d = ST_CMD;
            end
        endcase
    end

    // SCK is low for the first SPI_DIV cycles of a bit and high for the rest.
    // Deriving it from cs_n_q forces it low as soon as reset hits.
    assign spi_cs_n  = cs_n_q;
    assign spi_sck   = ~cs_n_q && (ph_q >= PH_W'(SPI_DIV));
    assign spi_mosi  = ~cs_n_q && (state_q == ST_CMD) && cmd_q[31];
    assign load_done = done_q;

    // -------------------------------------------------------------------------
    // 64 KB RAM. The loader owns the write port until load_done.
    // -------------------------------------------------------------------------
    logic [7:0]  mem [0:65535];
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  cpu_rd_q, cpu_rd_d;
    logic [7:0]  scrub_rd_q, scrub_rd_d;

    always_comb begin
        wr_en   = ld_we;
        wr_addr = ld_addr;
        wr_data = ld_data;
        if (done_q) begin
            wr_en   = ram_cpu_we;
            wr_addr = ram_cpu_A;
            wr_data = ram_cpu_D_wr;
        end
    end

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        cpu_rd_d   = mem[ram_cpu_A];
        scrub_rd_d = mem[ram_scrub_A];
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            cpu_rd_q   <= '0;
            scrub_rd_q <= '0;
        end else begin
            cpu_rd_q   <= cpu_rd_d;
            scrub_rd_q <= scrub_rd_d;
        end
    end

    assign ram_cpu_D_rd   = cpu_rd_q;
    assign ram_scrub_D_rd = scrub_rd_q;

endmodule

// File: tb/tb_beeb_fast_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_beeb_fast_ram_loader
//
// Three loaders run side by side from one clock:
//   dut 0: FLASH_BASE=0x010000, LOAD_START=0x8000, LOAD_LEN=4 (main tests)
//   dut 1: LOAD_LEN=0 (no load)
//   dut 2: FLASH_BASE=0x010000, LOAD_START=0xFFFE, LOAD_LEN=4 (address wrap)
// Each has an SPI flash model holding A9 00 85 70 at the image base.
// -----------------------------------------------------------------------------
module tb_beeb_fast_ram_loader;

    localparam int N     = 3;
    localparam int K_CPU = 0;
    localparam int K_SCR = 1;
    localparam int K_DONE = 2;
    localparam int K_CSN = 3;
    localparam int K_SCK = 4;

    typedef struct {
        int         kind;
        int         dut;
        int         cyc;
        logic [7:0] exp;
        string      name;
    } exp_t;

    // ------------------------------------------------------------------ clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [N];
    logic [15:0] cpu_a  [N];
    logic        cpu_we [N];
    logic [7:0]  cpu_wd [N];
    logic [15:0] scr_a  [N];
    wire  [7:0]  cpu_rd [N];
    wire  [7:0]  scr_rd [N];
    wire         cs_n   [N];
    wire         sck    [N];
    wire         mosi   [N];
    wire         miso   [N];
    wire         done   [N];
    wire  [31:0] cmd_w  [N];

    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    logic b_cs_low = 1'b0;

    // ------------------------------------------------------------------- DUTs
    beeb_fast_ram_loader #(
        .FLASH_BASE(24'h010000), .LOAD_START(16'h8000),
        .LOAD_LEN(17'd4), .SPI_DIV(2)
    ) dut_a (
        .cpu_clk(clk), .reset(rst[0]),
        .ram_cpu_A(cpu_a[0]), .ram_cpu_we(cpu_we[0]), .ram_cpu_D_wr(cpu_wd[0]),
        .ram_cpu_D_rd(cpu_rd[0]), .ram_scrub_A(scr_a[0]), .ram_scrub_D_rd(scr_rd[0]),
        .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]),
        .load_done(done[0])
    );

    beeb_fast_ram_loader #(
        .FLASH_BASE(24'h000000), .LOAD_START(16'h8000),
        .LOAD_LEN(17'd0), .SPI_DIV(2)
    ) dut_b (
        .cpu_clk(clk), .reset(rst[1]),
        .ram_cpu_A(cpu_a[1]), .ram_cpu_we(cpu_we[1]), .ram_cpu_D_wr(cpu_wd[1]),
        .ram_cpu_D_rd(cpu_rd[1]), .ram_scrub_A(scr_a[1]), .ram_scrub_D_rd(scr_rd[1]),
        .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]),
        .load_done(done[1])
    );

    beeb_fast_ram_loader #(
        .FLASH_BASE(24'h010000), .LOAD_START(16'hFFFE),
        .LOAD_LEN(17'd4), .SPI_DIV(2)
    ) dut_c (
        .cpu_clk(clk), .reset(rst[2]),
        .ram_cpu_A(cpu_a[2]), .ram_cpu_we(cpu_we[2]), .ram_cpu_D_wr(cpu_wd[2]),
        .ram_cpu_D_rd(cpu_rd[2]), .ram_scrub_A(scr_a[2]), .ram_scrub_D_rd(scr_rd[2]),
        .spi_cs_n(cs_n[2]), .spi_sck(sck[2]), .spi_mosi(mosi[2]), .spi_miso(miso[2]),
        .load_done(done[2])
    );

    // ------------------------------------------------------------ flash image
    function automatic logic [7:0] img(int i);
        case (i)
            0:       return 8'hA9;
            1:       return 8'h00;
            2:       return 8'h85;
            3:       return 8'h70;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------- SPI flash models
    // Mode 0: command bits captured on SCK rise, data driven after SCK fall.
    for (genvar g = 0; g < N; g++) begin : g_flash
        int          bit_cnt = 0;
        int          k       = 0;
        logic [7:0]  byte_v  = 8'h00;
        logic [31:0] cmd     = '0;
        logic        miso_b  = 1'b0;

        assign miso[g]  = miso_b;
        assign cmd_w[g] = cmd;

        always @(negedge cs_n[g] or posedge sck[g]) begin
            if (sck[g] === 1'b1) begin
                if (bit_cnt < 32) cmd = {cmd[30:0], mosi[g]};
                bit_cnt = bit_cnt + 1;
            end else begin
                bit_cnt = 0;
                cmd     = '0;
            end
        end

        always @(negedge sck[g]) begin
            if (cs_n[g] === 1'b0 && bit_cnt >= 32) begin
                k      = bit_cnt - 32;
                byte_v = img(k / 8);
                #1 miso_b = byte_v[7 - (k % 8)];
            end
        end
    end

    // The no-load instance must never select the flash.
    always @(negedge cs_n[1]) b_cs_low = 1'b1;

    // -------------------------------------------------------------- checking
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [7:0] actual(int kind, int d);
        case (kind)
            K_CPU:   return cpu_rd[d];
            K_SCR:   return scr_rd[d];
            K_DONE:  return {7'd0, done[d]};
            K_CSN:   return {7'd0, cs_n[d]};
            default: return {7'd0, sck[d]};
        endcase
    endfunction

    // Monitor: each edge, compare every expectation scheduled for this cycle.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                e = exp_q[i];
                exp_q.delete(i);
                check(e.name, 32'(actual(e.kind, e.dut)), 32'(e.exp));
            end
        end
    end

    // ---------------------------------------------------------- driver tasks
    task automatic push(int kind, int d, int at, logic [7:0] v, string name);
        exp_t e;
        e.kind = kind;
        e.dut  = d;
        e.cyc  = at;
        e.exp  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic cpu_op(int d, logic [15:0] a, logic we, logic [7:0] wd,
                          bit chk, logic [7:0] v, string name);
        @(negedge clk);
        cpu_a[d]  = a;
        cpu_we[d] = we;
        cpu_wd[d] = wd;
        if (chk) push(K_CPU, d, cyc + 1, v, name);
    endtask

    task automatic scr_op(int d, logic [15:0] a, logic [7:0] v, string name);
        @(negedge clk);
        scr_a[d] = a;
        push(K_SCR, d, cyc + 1, v, name);
    endtask

    task automatic cpu_idle(int d);
        @(negedge clk);
        cpu_we[d] = 1'b0;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int         base;
        int         base2;
        int         base3;
        logic [15:0] a;
        exp_t       e;

        for (int d = 0; d < N; d++) begin
            rst[d]    = 1'b1;
            cpu_a[d]  = '0;
            cpu_we[d] = 1'b0;
            cpu_wd[d] = '0;
            scr_a[d]  = '0;
        end
        repeat (3) @(negedge clk);

        // Reset values
        for (int d = 0; d < N; d++) begin
            check("rst_cs_n",  32'(cs_n[d]),   32'd1);
            check("rst_sck",   32'(sck[d]),    32'd0);
            check("rst_mosi",  32'(mosi[d]),   32'd0);
            check("rst_done",  32'(done[d]),   32'd0);
            check("rst_cpu_rd", 32'(cpu_rd[d]), 32'd0);
            check("rst_scr_rd", 32'(scr_rd[d]), 32'd0);
        end

        // Release every instance together; edge base+1 is cycle 1.
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
        base = cyc;
        push(K_CSN,  0, base + 1,   8'd0, "a_cs_low_c1");
        push(K_SCK,  0, base + 2,   8'd0, "a_sck_low_phase");
        push(K_SCK,  0, base + 3,   8'd1, "a_sck_high_phase");
        push(K_DONE, 0, base + 256, 8'd0, "a_done_early");
        push(K_DONE, 0, base + 257, 8'd1, "a_done_257");
        push(K_CSN,  0, base + 257, 8'd1, "a_cs_high_end");
        push(K_SCK,  0, base + 257, 8'd0, "a_sck_low_end");
        push(K_DONE, 1, base + 1,   8'd1, "b_done_c1");
        push(K_CSN,  1, base + 1,   8'd1, "b_cs_high_c1");
        push(K_DONE, 2, base + 256, 8'd0, "c_done_early");
        push(K_DONE, 2, base + 257, 8'd1, "c_done_257");

        // No-load instance accepts CPU writes from cycle 2 on.
        cpu_op(1, 16'h1234, 1'b1, 8'hC3, 1'b0, 8'h00, "");
        cpu_op(1, 16'h1234, 1'b0, 8'h00, 1'b1, 8'hC3, "b_wr_after_done");

        // CPU write during load must be ignored.
        cpu_op(0, 16'h8001, 1'b1, 8'h55, 1'b0, 8'h00, "");
        cpu_idle(0);

        wait_cyc(base + 262);
        check("a_cmd", cmd_w[0], 32'h03010000);
        check("c_cmd", cmd_w[2], 32'h03010000);
        check("b_cs_never_low", 32'(b_cs_low), 32'd0);

        for (int i = 0; i < 4; i++) cpu_op(0, 16'h8000 + 16'(i), 1'b0, 8'h00, 1'b1, img(i), "a_loaded");
        for (int i = 0; i < 4; i++) begin
            a = 16'hFFFE + 16'(i);
            cpu_op(2, a, 1'b0, 8'h00, 1'b1, img(i), "c_wrapped");
        end
        scr_op(0, 16'h8003, 8'h70, "a_scrub_loaded");

        // CPU writes after done, scrub view, read-first on the CPU port.
        cpu_op(0, 16'h3000, 1'b1, 8'h5A, 1'b0, 8'h00, "");
        cpu_op(0, 16'h3000, 1'b0, 8'h00, 1'b1, 8'h5A, "a_rd_after_wr");
        scr_op(0, 16'h3000, 8'h5A, "a_scrub_3000");
        cpu_op(0, 16'h3000, 1'b1, 8'h77, 1'b1, 8'h5A, "a_read_first");
        cpu_op(0, 16'h3000, 1'b0, 8'h00, 1'b1, 8'h77, "a_rd_new");

        // Overwrite the image so a reload is visible.
        for (int i = 0; i < 4; i++) cpu_op(0, 16'h8000 + 16'(i), 1'b1, 8'hFF, 1'b0, 8'h00, "");
        cpu_idle(0);
        cpu_op(0, 16'h8002, 1'b0, 8'h00, 1'b1, 8'hFF, "a_ff_written");

        // Second load, aborted during the third data byte with SCK high.
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        base2 = cyc;
        push(K_CSN, 0, base2 + 1, 8'd0, "a2_cs_low_c1");
        wait_cyc(base2 + 195);
        check("a2_sck_high_pre", 32'(sck[0]), 32'd1);
        check("a2_cs_low_pre",   32'(cs_n[0]), 32'd0);
        #2 rst[0] = 1'b1;
        #1;
        check("a2_async_cs_n", 32'(cs_n[0]), 32'd1);
        check("a2_async_sck",  32'(sck[0]),  32'd0);
        check("a2_async_done", 32'(done[0]), 32'd0);

        @(negedge clk);
        rst[0] = 1'b0;
        base3 = cyc;
        push(K_DONE, 0, base3 + 256, 8'd0, "a3_done_early");
        push(K_DONE, 0, base3 + 257, 8'd1, "a3_done_257");

        // Bytes written before the abort stay; the rest still hold FF.
        cpu_op(0, 16'h8000, 1'b0, 8'h00, 1'b1, 8'hA9, "a3_kept_0");
        cpu_op(0, 16'h8001, 1'b0, 8'h00, 1'b1, 8'h00, "a3_kept_1");
        cpu_op(0, 16'h8002, 1'b0, 8'h00, 1'b1, 8'hFF, "a3_not_yet_2");
        cpu_op(0, 16'h8003, 1'b0, 8'h00, 1'b1, 8'hFF, "a3_not_yet_3");

        wait_cyc(base3 + 262);
        check("a3_cmd", cmd_w[0], 32'h03010000);
        for (int i = 0; i < 4; i++) cpu_op(0, 16'h8000 + 16'(i), 1'b0, 8'h00, 1'b1, img(i), "a3_reloaded");

        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tot = n_tot + 1;
            $display("FAIL %s: never sampled, scheduled for cycle %0d, now %0d", e.name, e.cyc, cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
